tapa_multi_task_fsm: RTL and testbench
======================================

# tapa_multi_task_fsm

Slot-level ap_ctrl_hs controller that sequences `NUM_TASKS` child task instances placed in one floorplan slot. On a global start it latches the top-level scalar argument and launches every child in parallel. It tracks each child's ready/done handshake independently and signals global done once all children have finished. It generalises the single-task slot FSM generated by graphir conversion to slots holding several tasks, and adds a run-cycle counter for profiling.

## Interface
- `NUM_TASKS`, default 4: number of child tasks (1..16).
- `SCALAR_WIDTH`, default 64: width of the forwarded scalar argument.
- `CNT_WIDTH`, default 32: width of the run-cycle counter.

Ports:
- `ap_clk` in 1: sole clock; all logic is on the rising edge.
- `ap_rst` in 1: synchronous, active-high reset.
- `ap_start` in 1: global start, level-sensitive.
- `ap_ready` out 1: global ready.
- `ap_done` out 1: global done.
- `ap_idle` out 1: global idle.
- `scalar_in` in SCALAR_WIDTH: top-level scalar argument.
- `task_scalar` out SCALAR_WIDTH: registered copy of `scalar_in`, driven to all children.
- `task_ap_start` out NUM_TASKS: per-child start.
- `task_ap_ready` in NUM_TASKS: per-child ready.
- `task_ap_done` in NUM_TASKS: per-child done.
- `task_ap_idle` in NUM_TASKS: per-child idle; used for status only.
- `task_finished` out NUM_TASKS: per-child finished flag.
- `run_cycles` out CNT_WIDTH: length of the last or current run, in cycles.

## Operation
Global FSM `tapa_state`:
- IDLE=00 -> RUN=01 when `ap_start`=1. On that same edge, latch `task_scalar`<=`scalar_in` and clear `run_cycles` to 0.
- RUN -> DONE=10 when every per-task state is FINISHED, evaluated on registered states.
- DONE -> IDLE unconditionally.
- Encoding 11 is unreachable. If it occurs, it returns to IDLE.
- `ap_start` is ignored in RUN and DONE.

Per-task FSM `i` (same structure for every child):
- IDLE=00 -> START=01 when the global FSM takes its IDLE->RUN transition.
- START:
  - `task_ap_ready[i]`=1 and `task_ap_done[i]`=1 -> FINISHED=10.
  - `task_ap_ready[i]`=1 and `task_ap_done[i]`=0 -> WAIT=11.
  - `task_ap_done[i]` without `task_ap_ready[i]`: ignored, stays in START.
- WAIT -> FINISHED when `task_ap_done[i]`=1.
- FINISHED -> IDLE when the global state is DONE.

Outputs:
- `task_ap_start[i]` = (task state == START).
- `task_finished[i]` = (task state == FINISHED).
- `ap_idle` = (global state == IDLE).
- `ap_done` = `ap_ready` = (global state == DONE).
- `task_ap_idle` has no effect on any state.

Run-cycle counter:
- `run_cycles` increments by 1 on every cycle the global state is RUN.
- It saturates at all-ones and holds its value outside RUN.

## Timing
Reset values:
- Global state and all task states are IDLE.
- `task_scalar`=0, `run_cycles`=0.
- `ap_idle`=1; `ap_done`, `ap_ready`, `task_ap_start` and `task_finished` are all 0.
- All outputs are registered state or decoded from registered state; there is no combinational path from inputs to outputs.

Latency, with `ap_start` sampled at cycle 0:
- `task_ap_start` is 1 from cycle 1.
- A child's ready+done at cycle k gives `task_finished` at k+1.
- The last child finishing at cycle m gives `ap_done` at m+1, asserted for exactly one cycle.
- `ap_idle` returns at m+2.
- Minimum run: `ap_done` at cycle 3, `run_cycles`=2.

Boundary conditions:
- `ap_start` held high: the next run launches on the cycle `ap_idle` rises, so `ap_done` pulses have a period of at least 4 cycles.
- Children finishing on different cycles: the early finishers hold FINISHED until the global state is DONE.
- `task_ap_done[i]` asserted while task `i` is in IDLE or FINISHED: ignored.
- `ap_rst` asserted in any state: all state returns to reset values on the next edge, and `task_ap_start` drops on that edge.
- `ap_rst` and `ap_start` asserted together: reset wins.

## Test plan
- NUM_TASKS=4, all children return ready+done at cycle 1 -> `task_ap_start`=4'hF during cycle 1 only; `ap_done`=1 at cycle 3; `run_cycles`=2; `ap_idle`=1 at cycle 4.
- Children finish at cycles 2, 5, 9, 3, each with ready at cycle 1 and done later -> `task_finished` bits rise at cycles 3, 6, 10, 4; `ap_done` at cycle 11 only; `run_cycles`=10.
- `scalar_in`=64'hDEAD_BEEF_0000_0001 at start, changed to 0 at cycle 2 -> `task_scalar` holds DEAD_BEEF_0000_0001 until the next start.
- `ap_start` tied to 1, immediate children -> `ap_done` pulses at cycles 3, 7, 11; `ap_start` pulses during RUN launch nothing.
- `ap_rst`=1 at cycle 4 during WAIT -> at cycle 5 all states are IDLE, `ap_idle`=1, `task_ap_start`=0, `run_cycles`=0; a later `task_ap_done` is ignored.
- Child 2 asserts done without ready in START -> it stays in START with `task_ap_start[2]`=1 until ready arrives.

Source files
------------

// File: rtl/tapa_multi_task_fsm.sv
// Slot-level ap_ctrl_hs controller: launches NUM_TASKS children in parallel on a
// global start, tracks each child's ready/done handshake, raises a one-cycle
// global done once every child has finished, and counts run cycles.
module tapa_multi_task_fsm #(
  parameter int unsigned NUM_TASKS    = 4,
  parameter int unsigned SCALAR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_ready,
  output logic                    ap_done,
  output logic                    ap_idle,
  input  logic [SCALAR_WIDTH-1:0] scalar_in,
  output logic [SCALAR_WIDTH-1:0] task_scalar,
  output logic [NUM_TASKS-1:0]    task_ap_start,
  input  logic [NUM_TASKS-1:0]    task_ap_ready,
  input  logic [NUM_TASKS-1:0]    task_ap_done,
  input  logic [NUM_TASKS-1:0]    task_ap_idle,
  output logic [NUM_TASKS-1:0]    task_finished,
  output logic [CNT_WIDTH-1:0]    run_cycles
);

  // Global states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Per-task states
  localparam logic [1:0] TS_IDLE     = 2'b00;
  localparam logic [1:0] TS_START    = 2'b01;
  localparam logic [1:0] TS_FINISHED = 2'b10;
  localparam logic [1:0] TS_WAIT     = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]              r_tapa_state;
  logic [1:0]              w_tapa_state_next;
  logic [1:0]              r_task_state [NUM_TASKS];
  logic [1:0]              w_task_state_next [NUM_TASKS];
  logic [SCALAR_WIDTH-1:0] r_task_scalar;
  logic [CNT_WIDTH-1:0]    r_run_cycles;
  logic                    w_launch;
  logic                    w_all_finished;
  logic                    w_unused_idle;

  // Child idle is status only; it never steers any state.
  assign w_unused_idle = ^task_ap_idle;

  assign w_launch = (r_tapa_state == ST_IDLE) && ap_start;

  // All children finished, judged on registered task states only.
  always_comb begin
    w_all_finished = 1'b1;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (r_task_state[i] != TS_FINISHED) w_all_finished = 1'b0;
    end
  end

  // Global next state; the unused encoding falls back to IDLE.
  always_comb begin
    w_tapa_state_next = r_tapa_state;
    case (r_tapa_state)
      ST_IDLE: if (ap_start) w_tapa_state_next = ST_RUN;
      ST_RUN:  if (w_all_finished) w_tapa_state_next = ST_DONE;
      ST_DONE: w_tapa_state_next = ST_IDLE;
      default: w_tapa_state_next = ST_IDLE;
    endcase
  end

  // Per-task next state; done without ready is ignored while in START.
  always_comb begin
    for (int i = 0; i < NUM_TASKS; i++) begin
      w_task_state_next[i] = r_task_state[i];
      case (r_task_state[i])
        TS_IDLE:  if (w_launch) w_task_state_next[i] = TS_START;
        TS_START: begin
          if (task_ap_ready[i]) begin
            w_task_state_next[i] = task_ap_done[i] ? TS_FINISHED : TS_WAIT;
          end
        end
        TS_WAIT:  if (task_ap_done[i]) w_task_state_next[i] = TS_FINISHED;
        default:  if (r_tapa_state == ST_DONE) w_task_state_next[i] = TS_IDLE;
      endcase
    end
  end

  // State, scalar latch and run counter registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tapa_state  <= ST_IDLE;
      r_task_scalar <= '0;
      r_run_cycles  <= '0;
      for (int i = 0; i < NUM_TASKS; i++) r_task_state[i] <= TS_IDLE;
    end else begin
      r_tapa_state <= w_tapa_state_next;
      for (int i = 0; i < NUM_TASKS; i++) r_task_state[i] <= w_task_state_next[i];
      if (w_launch) begin
        r_task_scalar <= scalar_in;
        r_run_cycles  <= '0;
      end else if ((r_tapa_state == ST_RUN) && (r_run_cycles != CNT_MAX)) begin
        r_run_cycles <= r_run_cycles + CNT_ONE;
      end
    end
  end

  // Per-child outputs decoded from registered task states.
  always_comb begin
    task_ap_start = '0;
    task_finished = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      task_ap_start[i] = (r_task_state[i] == TS_START);
      task_finished[i] = (r_task_state[i] == TS_FINISHED);
    end
  end

  assign ap_idle     = (r_tapa_state == ST_IDLE);
  assign ap_done     = (r_tapa_state == ST_DONE);
  assign ap_ready    = (r_tapa_state == ST_DONE);
  assign task_scalar = r_task_scalar;
  assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_tapa_multi_task_fsm.sv
// Self-checking bench for tapa_multi_task_fsm: a run-level model checked every
// cycle, plus literal expectations at specific cycles of directed runs.
module tb_tapa_multi_task_fsm;

  localparam int NT = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_ready, ap_done, ap_idle;
  logic [63:0]   scalar_in, task_scalar;
  logic [NT-1:0] task_ap_start, task_ap_ready, task_ap_done, task_ap_idle, task_finished;
  logic [31:0]   run_cycles;

  // Small instance for counter saturation.
  logic       s_start, s_ready_o, s_done_o, s_idle_o;
  logic [7:0] s_scalar_in, s_scalar_o;
  logic [0:0] s_tstart, s_tready, s_tdone, s_tidle, s_tfin;
  logic [2:0] s_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  tapa_multi_task_fsm #(.NUM_TASKS(NT), .SCALAR_WIDTH(64), .CNT_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .scalar_in(scalar_in), .task_scalar(task_scalar),
    .task_ap_start(task_ap_start), .task_ap_ready(task_ap_ready),
    .task_ap_done(task_ap_done), .task_ap_idle(task_ap_idle),
    .task_finished(task_finished), .run_cycles(run_cycles)
  );

  tapa_multi_task_fsm #(.NUM_TASKS(1), .SCALAR_WIDTH(8), .CNT_WIDTH(3)) dut_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(s_start),
    .ap_ready(s_ready_o), .ap_done(s_done_o), .ap_idle(s_idle_o),
    .scalar_in(s_scalar_in), .task_scalar(s_scalar_o),
    .task_ap_start(s_tstart), .task_ap_ready(s_tready),
    .task_ap_done(s_tdone), .task_ap_idle(s_tidle),
    .task_finished(s_tfin), .run_cycles(s_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge ap_clk);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!ap_idle && k < budget) begin
      next_cycle();
      k++;
    end
    check("wait_idle_timeout", 64'(ap_idle), 64'd1);
  endtask

  // Run-level model: a run is busy from launch until every child has reported
  // done (after ready), then a single done cycle, then idle.
  logic          m_valid = 1'b0;
  logic          m_busy, m_done;
  logic [NT-1:0] m_pend, m_fin;
  logic [63:0]   m_scalar;
  logic [31:0]   m_cycles;

  always @(posedge ap_clk) begin
    if (ap_rst) begin
      m_valid  <= 1'b1;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_pend   <= '0;
      m_fin    <= '0;
      m_scalar <= '0;
      m_cycles <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_fin  <= '0;
    end else if (!m_busy) begin
      if (ap_start) begin
        m_busy   <= 1'b1;
        m_pend   <= '1;
        m_scalar <= scalar_in;
        m_cycles <= '0;
      end
    end else begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles <= m_cycles + 32'd1;
      if (&m_fin) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        for (int i = 0; i < NT; i++) begin
          if (m_pend[i]) begin
            if (task_ap_ready[i]) begin
              m_pend[i] <= 1'b0;
              if (task_ap_done[i]) m_fin[i] <= 1'b1;
            end
          end else if (!m_fin[i] && task_ap_done[i]) begin
            m_fin[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare of the main instance against the model.
  always @(negedge ap_clk) begin
    if (m_valid) begin
      check("m_ap_idle", 64'(ap_idle), 64'(!m_busy && !m_done));
      check("m_ap_done", 64'(ap_done), 64'(m_done));
      check("m_ap_ready", 64'(ap_ready), 64'(m_done));
      check("m_task_ap_start", 64'(task_ap_start), 64'(m_pend));
      check("m_task_finished", 64'(task_finished), 64'(m_fin));
      check("m_task_scalar", task_scalar, m_scalar);
      check("m_run_cycles", 64'(run_cycles), 64'(m_cycles));
    end
  end

  int fin_at [NT] = '{2, 5, 9, 3};

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; scalar_in = '0;
    task_ap_ready = '0; task_ap_done = '0; task_ap_idle = '0;
    s_start = 1'b0; s_scalar_in = '0; s_tready = '0; s_tdone = '0; s_tidle = '0;
    repeat (2) next_cycle();
    ap_rst = 1'b0;
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_start", 64'(task_ap_start), 64'd0);
    check("rst_cycles", 64'(run_cycles), 64'd0);
    check("rst_scalar", task_scalar, 64'd0);

    // Minimum run: all children ready+done in cycle 1.
    scalar_in = 64'h0000_0000_0000_00AA;
    ap_start  = 1'b1;
    next_cycle();
    check("t1_start_c1", 64'(task_ap_start), 64'hF);
    ap_start = 1'b0; task_ap_ready = '1; task_ap_done = '1;
    next_cycle();
    check("t1_start_c2", 64'(task_ap_start), 64'h0);
    check("t1_fin_c2", 64'(task_finished), 64'hF);
    task_ap_ready = '0; task_ap_done = '0;
    next_cycle();
    check("t1_done_c3", 64'(ap_done), 64'd1);
    check("t1_cycles_c3", 64'(run_cycles), 64'd2);
    next_cycle();
    check("t1_idle_c4", 64'(ap_idle), 64'd1);
    check("t1_done_c4", 64'(ap_done), 64'd0);
    next_cycle();

    // Staggered finishes; scalar changes mid-run; stray done on a finished child.
    scalar_in = 64'hDEAD_BEEF_0000_0001;
    ap_start  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      for (int i = 0; i < NT; i++) begin
        if (c == fin_at[i])     check("t2_fin_low", 64'(task_finished[i]), 64'd0);
        if (c == fin_at[i] + 1) check("t2_fin_rise", 64'(task_finished[i]), 64'd1);
      end
      check("t2_done", 64'(ap_done), 64'(c == 11));
      if (c == 11) check("t2_cycles", 64'(run_cycles), 64'd10);
      if (c == 12) check("t2_scalar_hold", task_scalar, 64'hDEAD_BEEF_0000_0001);
      ap_start = 1'b0;
      if (c == 2) scalar_in = '0;
      task_ap_ready = (c == 1) ? '1 : '0;
      for (int i = 0; i < NT; i++) task_ap_done[i] = (c == fin_at[i]) || (i == 0 && c == 6);
      task_ap_idle = 4'($urandom_range(0, 15));
    end
    task_ap_done = '0;
    next_cycle();

    // Start held high with immediate children.
    scalar_in = 64'h1234; ap_start = 1'b1; task_ap_ready = '1; task_ap_done = '1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      check("t4_done_pulse", 64'(ap_done), 64'(c == 3 || c == 7 || c == 11));
      if (c == 12) begin
        ap_start = 1'b0; task_ap_ready = '0; task_ap_done = '0;
      end
    end
    check("t4_scalar", task_scalar, 64'h1234);
    next_cycle();

    // Reset during WAIT, with start asserted alongside reset.
    scalar_in = 64'h55; ap_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      ap_start = 1'b0;
      task_ap_ready = (c == 1) ? '1 : '0;
      task_ap_done  = '0;
      if (c == 4) begin
        check("t5_busy_c4", 64'(ap_idle), 64'd0);
        ap_rst = 1'b1; ap_start = 1'b1;
      end
      if (c == 5) begin
        check("t5_idle", 64'(ap_idle), 64'd1);
        check("t5_start", 64'(task_ap_start), 64'd0);
        check("t5_cycles", 64'(run_cycles), 64'd0);
        check("t5_scalar", task_scalar, 64'd0);
        ap_rst = 1'b0; task_ap_done = '1;
      end
      if (c == 6) begin
        check("t5_fin_ignored", 64'(task_finished), 64'd0);
        check("t5_idle_c6", 64'(ap_idle), 64'd1);
      end
    end
    next_cycle();

    // Child 2 done without ready while in START.
    ap_start = 1'b1;
    next_cycle();
    ap_start = 1'b0; task_ap_ready = 4'b1011; task_ap_done = 4'b1111;
    next_cycle();
    check("t6_start_c2", 64'(task_ap_start), 64'b0100);
    task_ap_ready = 4'b0000; task_ap_done = 4'b0100;
    next_cycle();
    check("t6_start_c3", 64'(task_ap_start), 64'b0100);
    task_ap_ready = 4'b0100; task_ap_done = 4'b0100;
    next_cycle();
    check("t6_fin_c4", 64'(task_finished), 64'hF);
    task_ap_ready = '0; task_ap_done = '0;
    next_cycle();
    check("t6_done_c5", 64'(ap_done), 64'd1);
    wait_idle(10);

    // Counter saturation on the 3-bit instance.
    s_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      s_start = 1'b0;
      if (c == 5)  check("sat_cycles_c5", 64'(s_cycles), 64'd4);
      if (c == 10) begin
        check("sat_cycles_c10", 64'(s_cycles), 64'd7);
        s_tready = 1'b1; s_tdone = 1'b1;
      end
    end
    next_cycle();
    s_tready = 1'b0; s_tdone = 1'b0;
    next_cycle();
    check("sat_done", 64'(s_done_o), 64'd1);
    check("sat_hold", 64'(s_cycles), 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
